// File: rtl/map_bus_pkg.sv
// Shared types and constants for the mapper bus arbiter: FSM states,
// mapper channel indices and the values driven on an idle bus.
package map_bus_pkg;

  typedef enum logic [1:0] {
    ST_RUN,
    ST_DRAIN,
    ST_SETTLE
  } arb_state_t;

  localparam int CH_DLH     = 0;
  localparam int CH_CX4     = 1;
  localparam int CH_SDD1    = 2;
  localparam int CH_GSU     = 3;
  localparam int CH_SA1     = 4;
  localparam int CH_SPC7110 = 5;
  localparam int CH_BSX     = 6;

  localparam logic [7:0]  IDLE_DI     = 8'hFF;
  localparam logic        IDLE_STB_N  = 1'b1;
  localparam logic        IDLE_IRQ_N  = 1'b1;
  localparam logic        IDLE_WORD   = 1'b0;

endpackage

// File: rtl/map_sel_decode.sv
// Decodes the one-hot mapper request into a channel index; all-zero and
// multi-hot both map to channel 0, and multi-hot is flagged.
module map_sel_decode #(
  parameter int NCH = 7
) (
  input  logic [NCH-2:0]         map_active,
  output logic [$clog2(NCH)-1:0] target,
  output logic                   multi
);
  localparam int CW = $clog2(NCH);

  // NOTE: every output gets a default before the loop so no latch is inferred.
  always_comb begin
    target = '0;
    multi  = 1'b0;
    for (int k = 0; k < NCH - 1; k++) begin
      if (map_active[k]) begin
        if (target != '0) multi = 1'b1;
        target = CW'(k + 1);
      end
    end
    if (multi) target = '0;
  end

endmodule

// File: rtl/map_bus_arbiter.sv
// Routes one mapper channel's cartridge bus to the shared ROM/BSRAM/CPU side,
// draining the old channel and idling the bus for a few cycles on every switch.
module map_bus_arbiter
  import map_bus_pkg::*;
#(
  parameter int           NCH       = 7,
  parameter int           ROM_AW    = 24,
  parameter int           BS_AW     = 20,
  parameter int           SETTLE    = 2,
  parameter int           DRAIN_MAX = 16,
  parameter logic [NCH-1:0] TURBO_BLK = 'b0001010
) (
  input  logic                    mclk,
  input  logic                    rst,
  input  logic [NCH-2:0]          map_active,
  input  logic [8*NCH-1:0]        ch_do,
  input  logic [NCH-1:0]          ch_irq_n,
  input  logic [ROM_AW*NCH-1:0]   ch_rom_addr,
  input  logic [16*NCH-1:0]       ch_rom_d,
  input  logic [NCH-1:0]          ch_rom_ce_n,
  input  logic [NCH-1:0]          ch_rom_oe_n,
  input  logic [NCH-1:0]          ch_rom_we_n,
  input  logic [NCH-1:0]          ch_rom_word,
  input  logic [BS_AW*NCH-1:0]    ch_bs_addr,
  input  logic [8*NCH-1:0]        ch_bs_d,
  input  logic [NCH-1:0]          ch_bs_ce_n,
  input  logic [NCH-1:0]          ch_bs_oe_n,
  input  logic [NCH-1:0]          ch_bs_we_n,
  input  logic                    err_clr,
  output logic [7:0]              di,
  output logic                    irq_n,
  output logic [ROM_AW-1:0]       rom_addr,
  output logic [15:0]             rom_d,
  output logic                    rom_ce_n,
  output logic                    rom_oe_n,
  output logic                    rom_we_n,
  output logic                    rom_word,
  output logic [BS_AW-1:0]        bs_addr,
  output logic [7:0]              bs_d,
  output logic                    bs_ce_n,
  output logic                    bs_oe_n,
  output logic                    bs_we_n,
  output logic [$clog2(NCH)-1:0]  cur_ch,
  output logic                    busy,
  output logic [1:0]              err,
  output logic                    turbo_allow
);
  localparam int CW = $clog2(NCH);
  localparam int DW = $clog2(DRAIN_MAX + 1);

  logic [CW-1:0] target;
  logic          multi;

  map_sel_decode #(.NCH(NCH)) u_sel_decode (
    .map_active (map_active),
    .target     (target),
    .multi      (multi)
  );

  arb_state_t    state;
  logic [CW-1:0] tgt;
  logic [DW-1:0] drain_cnt;
  logic [3:0]    settle_cnt;

  logic released, timeout, drain_to;
  assign released = ch_rom_ce_n[cur_ch] & ch_bs_ce_n[cur_ch];
  assign timeout  = (drain_cnt >= DW'(DRAIN_MAX - 1));
  assign drain_to = (state == ST_DRAIN) && (target != cur_ch) && !released && timeout;

  // NOTE: all state is non-blocking; the reset branch also clears the data path.
  always_ff @(posedge mclk) begin
    if (rst) begin
      state       <= ST_RUN;
      cur_ch      <= CW'(CH_DLH);
      tgt         <= '0;
      drain_cnt   <= '0;
      settle_cnt  <= '0;
      busy        <= 1'b0;
      err         <= 2'b00;
      turbo_allow <= ~TURBO_BLK[0];
      di <= IDLE_DI;    irq_n <= IDLE_IRQ_N;
      rom_addr <= '0;   rom_d <= '0;
      rom_ce_n <= IDLE_STB_N; rom_oe_n <= IDLE_STB_N; rom_we_n <= IDLE_STB_N;
      rom_word <= IDLE_WORD;
      bs_addr <= '0;    bs_d <= '0;
      bs_ce_n <= IDLE_STB_N;  bs_oe_n <= IDLE_STB_N;  bs_we_n <= IDLE_STB_N;
    end else begin
      // The bus is idle exactly while the FSM sits in SETTLE, one cycle delayed.
      if (state == ST_SETTLE) begin
        di <= IDLE_DI;    irq_n <= IDLE_IRQ_N;
        rom_addr <= '0;   rom_d <= '0;
        rom_ce_n <= IDLE_STB_N; rom_oe_n <= IDLE_STB_N; rom_we_n <= IDLE_STB_N;
        rom_word <= IDLE_WORD;
        bs_addr <= '0;    bs_d <= '0;
        bs_ce_n <= IDLE_STB_N;  bs_oe_n <= IDLE_STB_N;  bs_we_n <= IDLE_STB_N;
      end else begin
        di       <= ch_do[cur_ch*8 +: 8];
        irq_n    <= ch_irq_n[cur_ch];
        rom_addr <= ch_rom_addr[cur_ch*ROM_AW +: ROM_AW];
        rom_d    <= ch_rom_d[cur_ch*16 +: 16];
        rom_ce_n <= ch_rom_ce_n[cur_ch];
        rom_oe_n <= ch_rom_oe_n[cur_ch];
        rom_we_n <= ch_rom_we_n[cur_ch];
        rom_word <= ch_rom_word[cur_ch];
        bs_addr  <= ch_bs_addr[cur_ch*BS_AW +: BS_AW];
        bs_d     <= ch_bs_d[cur_ch*8 +: 8];
        bs_ce_n  <= ch_bs_ce_n[cur_ch];
        bs_oe_n  <= ch_bs_oe_n[cur_ch];
        bs_we_n  <= ch_bs_we_n[cur_ch];
      end

      err[0] <= multi | (err[0] & ~err_clr);
      err[1] <= drain_to | (err[1] & ~err_clr);

      case (state)
        ST_RUN: begin
          if (target != cur_ch) begin
            state       <= ST_DRAIN;
            busy        <= 1'b1;
            drain_cnt   <= '0;
            turbo_allow <= 1'b0;
          end else begin
            turbo_allow <= ~TURBO_BLK[cur_ch];
          end
        end
        ST_DRAIN: begin
          if (target == cur_ch) begin
            state       <= ST_RUN;
            busy        <= 1'b0;
            turbo_allow <= ~TURBO_BLK[cur_ch];
          end else if (released || timeout) begin
            state      <= ST_SETTLE;
            settle_cnt <= '0;
            tgt        <= target;
          end else begin
            drain_cnt <= drain_cnt + 1'b1;
          end
        end
        ST_SETTLE: begin
          if (target != tgt) begin
            tgt        <= target;
            settle_cnt <= '0;
          end else if (settle_cnt >= 4'(SETTLE - 1)) begin
            state       <= ST_RUN;
            cur_ch      <= tgt;
            busy        <= 1'b0;
            turbo_allow <= ~TURBO_BLK[tgt];
          end else begin
            settle_cnt <= settle_cnt + 1'b1;
          end
        end
        default: state <= ST_RUN;
      endcase
    end
  end

endmodule
